// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer/FIFO-side bundle of the round-robin write arbiter.
//   req        producer request lines, one per producer
//   req_data   packed producer data, slice i = req_data[i*DATA_W +: DATA_W]
//   ack        one-hot write acknowledge back to the producers
//   fifo_full  FIFO full flag
//   fifo_wr_en FIFO write enable
//   fifo_data  FIFO data_in
//   owner      index of current grant holder (valid while busy)
//   busy       high while a producer holds the grant
// slave modport is the arbiter side; master modport is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [DATA_W-1:0]       fifo_data;
  logic [2:0]              owner;
  logic                    busy;

  modport slave (
    input  req, req_data, fifo_full,
    output ack, fifo_wr_en, fifo_data, owner, busy
  );

  modport master (
    output req, req_data, fifo_full,
    input  ack, fifo_wr_en, fifo_data, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// N_REQ producers. A granted producer may write up to MAX_BURST words, then
// ownership rotates. One idle arbitration cycle separates grants.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   arb   fifo_wr_arbiter_if.slave (req/req_data/ack, fifo_full/fifo_wr_en/
//         fifo_data, owner/busy status)
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rstn,
  fifo_wr_arbiter_if.slave  arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;

  logic [7:0]        req_ext;
  logic [DATA_W-1:0] data_sel;
  logic [N_REQ-1:0]  ack_d;
  logic              write;
  logic              pick_found;
  logic [2:0]        pick_idx;
  logic [3:0]        sum;

  // Datapath, write qualification and round-robin search
  always_comb begin
    req_ext  = '0;
    req_ext[N_REQ-1:0] = arb.req;
    data_sel = '0;
    ack_d    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == 3'(i))
        data_sel = arb.req_data[i*DATA_W +: DATA_W];
    end
    write = (state_q == GRANT) && req_ext[owner_q] && !arb.fifo_full;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      ack_d[i] = write && (owner_q == 3'(i));
    end

    // Search from last+1 with wrap; last < N_REQ and k <= N_REQ, so a single
    // conditional subtraction is enough for the modulo.
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last_q} + 4'(k);
      if (sum >= 4'(N_REQ))
        sum = sum - 4'(N_REQ);
      if (!pick_found && req_ext[sum[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = sum[2:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_ext[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (write) begin
          if (cnt_q == 4'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= 3'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign arb.ack        = ack_d;
  assign arb.fifo_wr_en = write;
  assign arb.fifo_data  = data_sel;
  assign arb.owner      = owner_q;
  assign arb.busy       = (state_q == GRANT);

endmodule
